text_display_timer: RTL

- Parametrised dwell timer for the text display path. Replaces the fixed-count display counter.
- Adds a runtime terminal count, start/stop control, one-shot or auto-reload mode, a busy/done status and an optional clock prescaler.
- Sits between the display sequencer, which issues start and stop, and the text scroller, which consumes end_pulse to advance to the next message.

---
 rtl/text_display_pkg.sv | 15 +
 rtl/tdt_prescaler.sv | 45 ++++
 rtl/text_display_timer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/text_display_pkg.sv
// Shared types and constants for the text display dwell timer.
package text_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } tdt_state_e;

  localparam int unsigned TDT_DEFAULT_TC = 10;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tdt_prescaler.sv
// Clock prescaler for the dwell timer: emits tick once every PRESCALE enabled clocks.
module tdt_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = enable && (pre_q == LAST);

  // Next prescaler value: clear wins, then wrap at LAST on enabled clocks.
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = {PW{1'b0}};
    end else if (enable) begin
      if (pre_q == LAST) begin
        pre_d = {PW{1'b0}};
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= {PW{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/text_display_timer.sv
// Dwell timer for the text display path (IDLE/RUN/DONE, one-shot or auto-reload).
// Optional prescaler enabled with `define TDT_PRESCALE_EN.
module text_display_timer
  import text_display_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEFAULT_TC = TDT_DEFAULT_TC,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             reload_mode,
  input  logic [WIDTH-1:0] term_count,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             end_pulse
);

  tdt_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             end_q, end_d;
  logic             tick_s;
  logic             term_tick_s;
  logic [WIDTH-1:0] tc_sel_s;

  assign tc_sel_s    = (term_count == {WIDTH{1'b0}}) ? WIDTH'(DEFAULT_TC) : term_count;
  assign term_tick_s = (state_q == RUN) && tick_s && (count_q == tc_q - WIDTH'(1))
                       && !start && !stop;

`ifdef TDT_PRESCALE_EN
  tdt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable && (state_q == RUN)),
    .clear   (start || stop || term_tick_s),
    .tick    (tick_s)
  );
`else
  // Without the prescaler every enabled clock is a tick; a zero PRESCALE stays illegal.
  localparam logic PRESCALE_OK = (PRESCALE >= 1);
  assign tick_s = enable && PRESCALE_OK;
`endif

  // Next-state and registered-output computation; stop beats start beats counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = tc_q;
    mode_d  = mode_q;
    end_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = {WIDTH{1'b0}};
    end else if (start) begin
      state_d = RUN;
      count_d = {WIDTH{1'b0}};
      tc_d    = tc_sel_s;
      mode_d  = reload_mode;
    end else begin
      case (state_q)
        RUN: begin
          if (term_tick_s) begin
            end_d = 1'b1;
            if (mode_q == MODE_RELOAD) begin
              count_d = {WIDTH{1'b0}};
            end else begin
              count_d = tc_q;
              state_d = DONE;
            end
          end else if (tick_s) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            count_d = count_q;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: begin
          state_d = IDLE;
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= {WIDTH{1'b0}};
      tc_q    <= WIDTH'(DEFAULT_TC);
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      end_q   <= end_d;
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign end_pulse = end_q;

endmodule
